// File: rtl/aes_stream_if_if.sv
// ---------------------------------------------------------------------------
// aes_stream_if_if
// Bundles every signal of the AES streaming wrapper apart from clk/rst.
//   Word input side : i_wvalid, i_wdata, i_mode, i_reuse_key -> o_wready
//   Core side       : o_start, o_mode, o_key, o_block <- i_core_ready, i_core_out
//   Result side     : o_rvalid, o_rdata <- i_rready
//   Status          : o_busy, o_timeout
// The master modport drives the word source, the core response and the
// result sink. The slave modport is the wrapper itself.
// ---------------------------------------------------------------------------
interface aes_stream_if_if;
    logic         i_wvalid;
    logic [31:0]  i_wdata;
    logic         i_mode;
    logic         i_reuse_key;
    logic         o_wready;
    logic         o_start;
    logic         o_mode;
    logic [127:0] o_key;
    logic [127:0] o_block;
    logic         i_core_ready;
    logic [127:0] i_core_out;
    logic         o_rvalid;
    logic [31:0]  o_rdata;
    logic         i_rready;
    logic         o_busy;
    logic         o_timeout;

    modport master (
        output i_wvalid, i_wdata, i_mode, i_reuse_key, i_core_ready, i_core_out, i_rready,
        input  o_wready, o_start, o_mode, o_key, o_block, o_rvalid, o_rdata, o_busy, o_timeout
    );

    modport slave (
        input  i_wvalid, i_wdata, i_mode, i_reuse_key, i_core_ready, i_core_out, i_rready,
        output o_wready, o_start, o_mode, o_key, o_block, o_rvalid, o_rdata, o_busy, o_timeout
    );
endinterface

// File: rtl/aes_stream_if.sv
// ---------------------------------------------------------------------------
// aes_stream_if
// Streams 32-bit words into a 128-bit AES core and streams the 128-bit
// result back out as four 32-bit words, MSW first.
// A job is 8 words (4 key words and then 4 data words) or, when the reuse flag
// sampled with the first word is set, 4 data words with the stored key.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - aes_stream_if_if.slave (word input, core control, result output,
//          busy and timeout status)
// Parameter:
//   TIMEOUT_CYC - WAIT cycles without i_core_ready before the job is dropped
// ---------------------------------------------------------------------------
module aes_stream_if #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic           clk,
    input  logic           rst,
    aes_stream_if_if.slave bus
);

    // The wait counter only has to reach TIMEOUT_CYC-1.
    localparam int WCW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_nxt;
    logic [2:0]     cnt_r;
    logic [WCW-1:0] wait_r;
    logic           reuse_r;
    logic           mode_r;
    logic [127:0]   key_r;
    logic [127:0]   block_r;
    logic [127:0]   result_r;
    logic [31:0]    rdata_r;
    logic           wready_r;
    logic           start_r;
    logic           rvalid_r;
    logic           timeout_r;
    logic           busy_r;

    logic           w_xfer_s;
    logic           r_xfer_s;
    logic           reuse_s;
    logic           key_word_s;
    logic           last_word_s;
    logic           capture_s;
    logic           expire_s;

    // Next-state decode and handshake qualifiers.
    always_comb begin
        state_nxt   = state_r;
        w_xfer_s    = bus.i_wvalid & wready_r;
        r_xfer_s    = rvalid_r & bus.i_rready;
        // The reuse flag only becomes a register after the first word, so in
        // IDLE the live input decides how that first word is routed.
        reuse_s     = (state_r == S_IDLE) ? bus.i_reuse_key : reuse_r;
        key_word_s  = ~reuse_s & ~cnt_r[2];
        last_word_s = reuse_s ? (cnt_r == 3'd3) : (cnt_r == 3'd7);
        capture_s   = (state_r == S_WAIT) & bus.i_core_ready;
        expire_s    = (state_r == S_WAIT) & ~bus.i_core_ready &
                      (wait_r == WCW'(TIMEOUT_CYC - 1));

        case (state_r)
            S_IDLE: begin
                if (w_xfer_s) begin
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_xfer_s && last_word_s) begin
                    state_nxt = S_START;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (capture_s) begin
                    state_nxt = S_DRAIN;
                end else if (expire_s) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (r_xfer_s && (cnt_r == 3'd3)) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Registered outputs, word assembly, counters and the result buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wready_r  <= 1'b0;
            start_r   <= 1'b0;
            rvalid_r  <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= 3'd0;
            wait_r    <= {WCW{1'b0}};
            reuse_r   <= 1'b0;
            mode_r    <= 1'b0;
            key_r     <= 128'h0;
            block_r   <= 128'h0;
            result_r  <= 128'h0;
            rdata_r   <= 32'h0;
        end else begin
            // Control outputs follow the state being entered, so each one is
            // valid in exactly the cycle its state is occupied.
            wready_r  <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
            start_r   <= (state_nxt == S_START);
            rvalid_r  <= (state_nxt == S_DRAIN);
            busy_r    <= (state_nxt != S_IDLE);
            timeout_r <= expire_s;

            // One counter serves both input words and output words; it is
            // zeroed on entry to IDLE and on entry to START.
            if ((state_nxt == S_IDLE) || (state_nxt == S_START)) begin
                cnt_r <= 3'd0;
            end else if (w_xfer_s || r_xfer_s) begin
                cnt_r <= cnt_r + 3'd1;
            end

            if ((state_r == S_WAIT) && (state_nxt == S_WAIT)) begin
                wait_r <= wait_r + WCW'(1);
            end else begin
                wait_r <= {WCW{1'b0}};
            end

            if (w_xfer_s && (state_r == S_IDLE)) begin
                mode_r  <= bus.i_mode;
                reuse_r <= bus.i_reuse_key;
            end

            // Words arrive MSW first, so shifting left lands word 0 in [127:96].
            // A reuse job never touches key_r, which keeps the previous key.
            if (w_xfer_s) begin
                if (key_word_s) begin
                    key_r <= {key_r[95:0], bus.i_wdata};
                end else begin
                    block_r <= {block_r[95:0], bus.i_wdata};
                end
            end

            if (capture_s) begin
                result_r <= bus.i_core_out;
                rdata_r  <= bus.i_core_out[127:96];
            end else if (r_xfer_s) begin
                result_r <= {result_r[95:0], 32'h0};
                rdata_r  <= result_r[95:64];
            end
        end
    end

    assign bus.o_wready  = wready_r;
    assign bus.o_start   = start_r;
    assign bus.o_mode    = mode_r;
    assign bus.o_key     = key_r;
    assign bus.o_block   = block_r;
    assign bus.o_rvalid  = rvalid_r;
    assign bus.o_rdata   = rdata_r;
    assign bus.o_busy    = busy_r;
    assign bus.o_timeout = timeout_r;

endmodule

// File: tb/tb_aes_stream_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_aes_stream_if
// Plays word source, AES core and result sink around aes_stream_if. Jobs come
// from a vector table and then from random draws. Expected key, block, mode
// and output words are derived from the job contents and a stored-key model.
// ---------------------------------------------------------------------------
module tb_aes_stream_if;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] key_model = 128'h0;

    aes_stream_if_if bus ();

    aes_stream_if #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         mode;
        logic         reuse;
        logic [127:0] key;
        logic [127:0] blk;
        logic [127:0] resp;
        int           lat;
        int           gap;
        int           rr;
        logic         noise;
        logic [127:0] exp_key;
        logic [127:0] exp_block;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vt[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_wready"}, bus.o_wready, 1'b0);
        chk1({tag, "_start"}, bus.o_start, 1'b0);
        chk1({tag, "_rvalid"}, bus.o_rvalid, 1'b0);
        chk1({tag, "_timeout"}, bus.o_timeout, 1'b0);
        chk1({tag, "_busy"}, bus.o_busy, 1'b0);
        chk1({tag, "_mode"}, bus.o_mode, 1'b0);
        chk({tag, "_key"}, bus.o_key, 128'h0);
        chk({tag, "_block"}, bus.o_block, 128'h0);
        chkw({tag, "_rdata"}, bus.o_rdata, 32'h0);
    endtask

    // Full job: load words (with optional gaps), act as the core with a
    // given latency, then drain the four result words under a ready pattern
    // (rr: 0 always ready, 1 toggling starting low, 2 random).
    task automatic run_job(input logic mode, input logic reuse, input logic [127:0] key,
                           input logic [127:0] blk, input logic [127:0] resp, input int lat,
                           input int gap, input int rr, input logic noise,
                           input logic [127:0] exp_key, input logic [127:0] exp_block,
                           input logic [127:0] exp_out);
        logic [31:0] q[$];
        int          idx;
        int          cyc;
        int          got;
        logic        vld;
        logic        xfer;
        logic        rdy;
        logic        held;
        logic [31:0] held_word;
        q = {};
        if (!reuse) begin
            for (int i = 0; i < 4; i++) q.push_back(key[127-32*i -: 32]);
        end
        for (int i = 0; i < 4; i++) q.push_back(blk[127-32*i -: 32]);

        idx = 0;
        cyc = 0;
        while (idx < q.size() && cyc < 400) begin
            vld = (gap == 0) || (int'($urandom_range(99)) >= gap);
            bus.i_wvalid    = vld;
            bus.i_wdata     = vld ? q[idx] : $urandom;
            // Only the first word's mode/reuse may matter; drive the opposite later.
            bus.i_mode      = (idx == 0) ? mode : ~mode;
            bus.i_reuse_key = (idx == 0) ? reuse : ~reuse;
            chk1("wready_load", bus.o_wready, 1'b1);
            xfer = vld && bus.o_wready;
            tick();
            if (xfer) idx++;
            cyc++;
            if (idx < q.size()) chk1("no_early_start", bus.o_start, 1'b0);
        end
        bus.i_wvalid = 1'b0;
        if (idx < q.size()) begin
            chkw("load_bound", 32'(idx), 32'(q.size()));
            return;
        end

        chk1("start_pulse", bus.o_start, 1'b1);
        chk1("wready_start", bus.o_wready, 1'b0);
        chk1("busy_start", bus.o_busy, 1'b1);
        chk("o_key", bus.o_key, exp_key);
        chk("o_block", bus.o_block, exp_block);
        chk1("o_mode", bus.o_mode, mode);

        // A core_ready during START must be ignored.
        bus.i_core_ready = noise;
        bus.i_core_out   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus.i_core_ready = 1'b0;
        chk1("start_one_cycle", bus.o_start, 1'b0);
        for (int k = 1; k < lat; k++) begin
            chk1("rvalid_early", bus.o_rvalid, 1'b0);
            tick();
        end
        bus.i_core_ready = 1'b1;
        bus.i_core_out   = resp;
        tick();
        bus.i_core_ready = 1'b0;
        bus.i_core_out   = {$urandom, $urandom, $urandom, $urandom};
        chk1("rvalid_latency", bus.o_rvalid, 1'b1);

        got  = 0;
        cyc  = 0;
        held = 1'b0;
        held_word = 32'h0;
        while (got < 4 && cyc < 100) begin
            if (rr == 0) begin
                rdy = 1'b1;
            end else if (rr == 1) begin
                rdy = ((cyc % 2) == 1);
            end else begin
                rdy = 1'($urandom_range(1));
            end
            bus.i_rready = rdy;
            chk1("rvalid_drain", bus.o_rvalid, 1'b1);
            chk1("wready_drain", bus.o_wready, 1'b0);
            if (held) chkw("rdata_hold", bus.o_rdata, held_word);
            if (rdy) begin
                chkw("rdata_word", bus.o_rdata, exp_out[127-32*got -: 32]);
                got++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                held_word = bus.o_rdata;
            end
            tick();
            cyc++;
        end
        bus.i_rready = 1'b0;
        chkw("drain_count", 32'(got), 32'd4);
        chk1("no_extra_word", bus.o_rvalid, 1'b0);
        chk1("busy_idle", bus.o_busy, 1'b0);
        chk1("wready_idle", bus.o_wready, 1'b1);
        chk("key_stable", bus.o_key, exp_key);
        chk("block_stable", bus.o_block, exp_block);
        chk1("mode_stable", bus.o_mode, mode);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         m;
        logic         r;
        logic [127:0] k;
        logic [127:0] b;
        logic [127:0] resp;
        int           cnt;
        logic         seen_to;

        bus.i_wvalid     = 1'b0;
        bus.i_wdata      = 32'h0;
        bus.i_mode       = 1'b0;
        bus.i_reuse_key  = 1'b0;
        bus.i_core_ready = 1'b0;
        bus.i_core_out   = 128'h0;
        bus.i_rready     = 1'b0;

        // Vector table. Entry 0 reuses the key before any load (key 0).
        vt[0] = '{mode: 1'b0, reuse: 1'b1, key: {4{32'hffff_ffff}},
                  blk: 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0,
                  resp: 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10,
                  lat: 3, gap: 0, rr: 0, noise: 1'b0,
                  exp_key: 128'h0, exp_block: 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0,
                  exp_out: 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10};
        vt[1] = '{mode: 1'b0, reuse: 1'b0, key: 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f,
                  blk: 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff,
                  resp: 128'h69c4_e0d8_6a7b_0430_d8cd_b780_70b4_c55a,
                  lat: 11, gap: 0, rr: 0, noise: 1'b0,
                  exp_key: 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f,
                  exp_block: 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff,
                  exp_out: 128'h69c4_e0d8_6a7b_0430_d8cd_b780_70b4_c55a};
        vt[2] = '{mode: 1'b1, reuse: 1'b1, key: {4{32'h5555_aaaa}},
                  blk: 128'h69c4_e0d8_6a7b_0430_d8cd_b780_70b4_c55a,
                  resp: 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff,
                  lat: 5, gap: 0, rr: 0, noise: 1'b0,
                  exp_key: 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f,
                  exp_block: 128'h69c4_e0d8_6a7b_0430_d8cd_b780_70b4_c55a,
                  exp_out: 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff};
        vt[3] = '{mode: 1'b0, reuse: 1'b1, key: 128'h0,
                  blk: 128'hcafe_0001_cafe_0002_cafe_0003_cafe_0004,
                  resp: 128'ha1a1_a1a1_b2b2_b2b2_c3c3_c3c3_d4d4_d4d4,
                  lat: 2, gap: 0, rr: 1, noise: 1'b1,
                  exp_key: 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f,
                  exp_block: 128'hcafe_0001_cafe_0002_cafe_0003_cafe_0004,
                  exp_out: 128'ha1a1_a1a1_b2b2_b2b2_c3c3_c3c3_d4d4_d4d4};
        vt[4] = '{mode: 1'b1, reuse: 1'b0, key: 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                  blk: 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000,
                  resp: 128'h0f0f_0f0f_f0f0_f0f0_3c3c_3c3c_c3c3_c3c3,
                  lat: 16, gap: 50, rr: 2, noise: 1'b0,
                  exp_key: 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                  exp_block: 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000,
                  exp_out: 128'h0f0f_0f0f_f0f0_f0f0_3c3c_3c3c_c3c3_c3c3};

        // Reset state.
        tick();
        tick();
        chk_reset_outputs("rst_init");
        rst = 1'b0;
        tick();
        chk1("wready_after_rst", bus.o_wready, 1'b1);
        chk1("busy_after_rst", bus.o_busy, 1'b0);
        tick();

        for (int i = 0; i < 5; i++) begin
            run_job(vt[i].mode, vt[i].reuse, vt[i].key, vt[i].blk, vt[i].resp, vt[i].lat,
                    vt[i].gap, vt[i].rr, vt[i].noise, vt[i].exp_key, vt[i].exp_block,
                    vt[i].exp_out);
            if (!vt[i].reuse) key_model = vt[i].key;
            tick();
        end

        // Timeout: core never answers; one START cycle plus TO WAIT cycles.
        b = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        for (int i = 0; i < 4; i++) begin
            bus.i_wvalid    = 1'b1;
            bus.i_wdata     = b[127-32*i -: 32];
            bus.i_mode      = 1'b0;
            bus.i_reuse_key = 1'b1;
            tick();
        end
        bus.i_wvalid = 1'b0;
        chk1("to_start", bus.o_start, 1'b1);
        cnt = 0;
        seen_to = 1'b0;
        while (!seen_to && cnt < 40) begin
            chk1("to_no_rvalid", bus.o_rvalid, 1'b0);
            tick();
            cnt++;
            seen_to = bus.o_timeout;
        end
        chkw("to_latency", 32'(cnt), 32'(TO + 1));
        chk1("to_idle_busy", bus.o_busy, 1'b0);
        chk1("to_idle_wready", bus.o_wready, 1'b1);
        chk1("to_rvalid", bus.o_rvalid, 1'b0);
        tick();
        chk1("to_one_cycle", bus.o_timeout, 1'b0);
        chk1("to_rvalid_after", bus.o_rvalid, 1'b0);

        // Reset in the middle of LOAD after 5 of 8 words.
        k = 128'hfeed_face_0123_4567_89ab_cdef_0f1e_2d3c;
        for (int i = 0; i < 5; i++) begin
            bus.i_wvalid    = 1'b1;
            bus.i_wdata     = (i < 4) ? k[127-32*i -: 32] : 32'habcd_ef01;
            bus.i_mode      = 1'b1;
            bus.i_reuse_key = 1'b0;
            chk1("mid_wready", bus.o_wready, 1'b1);
            tick();
        end
        bus.i_wvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        tick();
        chk_reset_outputs("rst_held");
        rst = 1'b0;
        chk1("rst_release_wready", bus.o_wready, 1'b0);
        tick();
        chk1("rst_first_edge_wready", bus.o_wready, 1'b1);
        key_model = 128'h0;
        run_job(1'b1, 1'b0, k, 128'h0102_0304_a0b0_c0d0_1122_3344_5566_7788,
                128'h8877_6655_4433_2211_0d0c_0b0a_0403_0201, 7, 0, 0, 1'b0,
                k, 128'h0102_0304_a0b0_c0d0_1122_3344_5566_7788,
                128'h8877_6655_4433_2211_0d0c_0b0a_0403_0201);
        key_model = k;
        tick();

        // Random jobs against the stored-key model.
        for (int j = 0; j < 16; j++) begin
            m    = 1'($urandom_range(1));
            r    = ($urandom_range(2) == 0);
            k    = {$urandom, $urandom, $urandom, $urandom};
            b    = {$urandom, $urandom, $urandom, $urandom};
            resp = {$urandom, $urandom, $urandom, $urandom};
            run_job(m, r, k, b, resp, int'($urandom_range(16, 1)), int'($urandom_range(60)),
                    int'($urandom_range(2)), 1'($urandom_range(1)),
                    r ? key_model : k, b, resp);
            if (!r) key_model = k;
            if ($urandom_range(1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
